mul_issue_arbiter: RTL and testbench

Issue-side controller for the shared pipelined integer multiplier. It arbitrates between two issue ports competing for the single multiplier input, oldest first by sequence number. It tracks every in-flight operation through a latency-matched shadow pipeline, kills tracked entries on branch mispredict, and honours writeback-port reservations from other units. It also provides a drain handshake so the pipeline can be quiesced.

---
 rtl/mul_issue_arbiter.sv | 132 +++++++++++++
 tb/tb_mul_issue_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_arbiter.sv
// Issue-side controller for the shared pipelined multiplier: oldest-first port
// arbitration, latency-matched kill tracking, writeback reservation and drain handshake.
module mul_issue_arbiter #(
    parameter int NUM_STAGES = 4,
    parameter int SQN_W      = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       IN_reqValid,
    input  logic [SQN_W-1:0] IN_reqSqN0,
    input  logic [SQN_W-1:0] IN_reqSqN1,
    input  logic             IN_branchValid,
    input  logic [SQN_W-1:0] IN_branchSqN,
    input  logic             IN_wbBlock,
    input  logic             IN_drain,
    output logic [1:0]       OUT_grant,
    output logic             OUT_en,
    output logic             OUT_sel,
    output logic             OUT_wbValid,
    output logic [2:0]       OUT_inflight,
    output logic             OUT_idle
);

    localparam int LAT = NUM_STAGES + 2;

    typedef enum logic [1:0] {
        RUN,
        DRAINING,
        DRAINED
    } state_t;

    state_t                    state;
    logic                      sel_q;
    logic [LAT-1:0]            trk_v;
    logic [LAT-1:0][SQN_W-1:0] trk_sqn;
    logic [LAT-1:0]            nxt_v;
    logic [LAT-1:0][SQN_W-1:0] nxt_sqn;
    logic [2:0]                inflight_d;
    logic [SQN_W-1:0]          diff01;
    logic                      port0_older;
    logic [1:0]                elig;

    // True when sqn is strictly younger than the mispredicted branch.
    function automatic logic is_killed(input logic             bv,
                                       input logic [SQN_W-1:0] bsqn,
                                       input logic [SQN_W-1:0] sqn);
        logic [SQN_W-1:0] diff;
        diff = sqn - bsqn;
        return bv && !diff[SQN_W-1] && (diff != '0);
    endfunction

    // Issuing is allowed exactly when the FSM will be in RUN next cycle, which
    // in every state reduces to IN_drain being low.
    always_comb begin
        diff01      = IN_reqSqN0 - IN_reqSqN1;
        port0_older = diff01[SQN_W-1] || (diff01 == '0);
        elig[0]     = rst && IN_reqValid[0] && !IN_wbBlock && !IN_drain &&
                      !is_killed(IN_branchValid, IN_branchSqN, IN_reqSqN0);
        elig[1]     = rst && IN_reqValid[1] && !IN_wbBlock && !IN_drain &&
                      !is_killed(IN_branchValid, IN_branchSqN, IN_reqSqN1);
        OUT_grant[0] = elig[0] && (!elig[1] || port0_older);
        OUT_grant[1] = elig[1] && (!elig[0] || !port0_older);
    end

    assign OUT_en      = |OUT_grant;
    assign OUT_sel     = OUT_en ? OUT_grant[1] : sel_q;
    assign OUT_wbValid = trk_v[LAT-1] &&
                         !is_killed(IN_branchValid, IN_branchSqN, trk_sqn[LAT-1]);

    always_comb begin
        nxt_v      = '0;
        nxt_sqn    = '0;
        nxt_v[0]   = OUT_en;
        nxt_sqn[0] = OUT_grant[1] ? IN_reqSqN1 : IN_reqSqN0;
        for (int unsigned i = 1; i < LAT; i++) begin
            nxt_v[i]   = trk_v[i-1] &&
                         !is_killed(IN_branchValid, IN_branchSqN, trk_sqn[i-1]);
            nxt_sqn[i] = trk_sqn[i-1];
        end
        inflight_d = '0;
        for (int unsigned i = 0; i < LAT; i++) begin
            inflight_d = inflight_d + {2'b00, nxt_v[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_v        <= '0;
            trk_sqn      <= '0;
            sel_q        <= 1'b0;
            OUT_inflight <= '0;
        end else begin
            trk_v        <= nxt_v;
            trk_sqn      <= nxt_sqn;
            sel_q        <= OUT_sel;
            OUT_inflight <= inflight_d;
        end
    end

    // Drain completes on the edge that leaves the tracker empty (slot 0 included).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            OUT_idle <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (IN_drain) state <= DRAINING;
                end
                DRAINING: begin
                    if (!IN_drain) begin
                        state <= RUN;
                    end else if (inflight_d == '0) begin
                        state    <= DRAINED;
                        OUT_idle <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!IN_drain) begin
                        state    <= RUN;
                        OUT_idle <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    OUT_idle <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Self-checking bench for mul_issue_arbiter: directed scenarios plus a randomized
// run compared against a queue-based model of in-flight operations.
module tb_mul_issue_arbiter;

    localparam int LAT = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] IN_reqValid;
    logic [6:0] IN_reqSqN0;
    logic [6:0] IN_reqSqN1;
    logic       IN_branchValid;
    logic [6:0] IN_branchSqN;
    logic       IN_wbBlock;
    logic       IN_drain;
    logic [1:0] OUT_grant;
    logic       OUT_en;
    logic       OUT_sel;
    logic       OUT_wbValid;
    logic [2:0] OUT_inflight;
    logic       OUT_idle;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0] sqn;
        int         due;
    } op_t;

    mul_issue_arbiter #(.NUM_STAGES(4), .SQN_W(7)) dut (
        .clk(clk), .rst(rst), .IN_reqValid(IN_reqValid),
        .IN_reqSqN0(IN_reqSqN0), .IN_reqSqN1(IN_reqSqN1),
        .IN_branchValid(IN_branchValid), .IN_branchSqN(IN_branchSqN),
        .IN_wbBlock(IN_wbBlock), .IN_drain(IN_drain),
        .OUT_grant(OUT_grant), .OUT_en(OUT_en), .OUT_sel(OUT_sel),
        .OUT_wbValid(OUT_wbValid), .OUT_inflight(OUT_inflight), .OUT_idle(OUT_idle)
    );

    always #5 clk = ~clk;

    // a is younger than b when (a - b) mod 128 lies in 1..63
    function automatic bit younger(input logic [6:0] a, input logic [6:0] b);
        int d;
        d = (int'(a) - int'(b) + 128) % 128;
        return (d >= 1) && (d <= 63);
    endfunction

    task automatic clear_inputs();
        IN_reqValid = 2'b00; IN_reqSqN0 = '0; IN_reqSqN1 = '0;
        IN_branchValid = 1'b0; IN_branchSqN = '0; IN_wbBlock = 1'b0; IN_drain = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic flush();
        clear_inputs();
        repeat (LAT + 1) next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        IN_reqValid = 2'b11; IN_reqSqN0 = 7'd3; IN_reqSqN1 = 7'd4;
        @(negedge clk);
        checks++; if (OUT_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", OUT_grant); end
        checks++; if (OUT_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", OUT_en); end
        checks++; if (OUT_inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", OUT_inflight); end
        checks++; if (OUT_wbValid !== 1'b0) begin errors++; $display("FAIL reset_wb got %b exp 0", OUT_wbValid); end
        checks++; if (OUT_sel !== 1'b0) begin errors++; $display("FAIL reset_sel got %b exp 0", OUT_sel); end
        checks++; if (OUT_idle !== 1'b0) begin errors++; $display("FAIL reset_idle got %b exp 0", OUT_idle); end
        next_cycle();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_single();
        clear_inputs();
        IN_reqValid = 2'b01; IN_reqSqN0 = 7'd5;
        @(negedge clk);
        checks++; if (OUT_grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", OUT_grant); end
        checks++; if (OUT_en !== 1'b1) begin errors++; $display("FAIL single_en got %b exp 1", OUT_en); end
        checks++; if (OUT_sel !== 1'b0) begin errors++; $display("FAIL single_sel got %b exp 0", OUT_sel); end
        next_cycle();
        clear_inputs();
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            checks++; if (OUT_inflight !== ((k <= LAT) ? 3'd1 : 3'd0)) begin
                errors++; $display("FAIL single_inflight k=%0d got %0d exp %0d", k, OUT_inflight, (k <= LAT) ? 1 : 0);
            end
            checks++; if (OUT_wbValid !== (k == LAT)) begin
                errors++; $display("FAIL single_wb k=%0d got %b exp %b", k, OUT_wbValid, (k == LAT));
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        clear_inputs();
        IN_reqValid = 2'b11; IN_reqSqN0 = 7'h7E; IN_reqSqN1 = 7'h01;
        @(negedge clk);
        checks++; if (OUT_grant !== 2'b01) begin errors++; $display("FAIL wrap_grant_a got %b exp 01", OUT_grant); end
        checks++; if (OUT_sel !== 1'b0) begin errors++; $display("FAIL wrap_sel_a got %b exp 0", OUT_sel); end
        next_cycle();
        IN_reqSqN0 = 7'h05; IN_reqSqN1 = 7'h03;
        @(negedge clk);
        checks++; if (OUT_grant !== 2'b10) begin errors++; $display("FAIL wrap_grant_b got %b exp 10", OUT_grant); end
        checks++; if (OUT_sel !== 1'b1) begin errors++; $display("FAIL wrap_sel_b got %b exp 1", OUT_sel); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (OUT_en !== 1'b0) begin errors++; $display("FAIL wrap_idle_en got %b exp 0", OUT_en); end
        checks++; if (OUT_sel !== 1'b1) begin errors++; $display("FAIL wrap_sel_hold got %b exp 1", OUT_sel); end
        flush();
    endtask

    task automatic test_flush();
        logic [1:0] exp_g [3];
        logic [6:0] sq    [3];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        sq[0] = 7'd10; sq[1] = 7'd11; sq[2] = 7'd12;
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            IN_reqValid = exp_g[c];
            if (exp_g[c] == 2'b01) IN_reqSqN0 = sq[c]; else IN_reqSqN1 = sq[c];
            @(negedge clk);
            checks++; if (OUT_grant !== exp_g[c]) begin errors++; $display("FAIL flush_grant c=%0d got %b exp %b", c, OUT_grant, exp_g[c]); end
            next_cycle();
        end
        clear_inputs();
        IN_branchValid = 1'b1; IN_branchSqN = 7'd10;
        @(negedge clk);
        checks++; if (OUT_inflight !== 3'd3) begin errors++; $display("FAIL flush_inflight_before got %0d exp 3", OUT_inflight); end
        checks++; if (OUT_wbValid !== 1'b0) begin errors++; $display("FAIL flush_wb_branch got %b exp 0", OUT_wbValid); end
        next_cycle();
        clear_inputs();
        // cycle numbering: grants at 1..3, branch at 4, sqN 10 result at 7
        for (int c = 5; c <= 10; c++) begin
            @(negedge clk);
            checks++; if (OUT_wbValid !== (c == 7)) begin errors++; $display("FAIL flush_wb c=%0d got %b exp %b", c, OUT_wbValid, (c == 7)); end
            checks++; if (OUT_inflight !== ((c <= 7) ? 3'd1 : 3'd0)) begin
                errors++; $display("FAIL flush_inflight c=%0d got %0d exp %0d", c, OUT_inflight, (c <= 7) ? 1 : 0);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch_same_cycle();
        clear_inputs();
        IN_branchValid = 1'b1; IN_branchSqN = 7'd20;
        IN_reqValid = 2'b11; IN_reqSqN0 = 7'd19; IN_reqSqN1 = 7'd21;
        @(negedge clk);
        checks++; if (OUT_grant !== 2'b01) begin errors++; $display("FAIL branch_mixed got %b exp 01", OUT_grant); end
        next_cycle();
        IN_reqValid = 2'b10;
        @(negedge clk);
        checks++; if (OUT_grant !== 2'b00) begin errors++; $display("FAIL branch_younger got %b exp 00", OUT_grant); end
        next_cycle();
        IN_reqSqN1 = 7'd20;
        @(negedge clk);
        checks++; if (OUT_grant !== 2'b10) begin errors++; $display("FAIL branch_equal got %b exp 10", OUT_grant); end
        flush();
    endtask

    task automatic test_wbblock();
        clear_inputs();
        IN_reqValid = 2'b11; IN_reqSqN0 = 7'd30; IN_reqSqN1 = 7'd31; IN_wbBlock = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (OUT_grant !== 2'b00) begin errors++; $display("FAIL wbblock_grant c=%0d got %b exp 00", c, OUT_grant); end
            next_cycle();
        end
        IN_wbBlock = 1'b0;
        @(negedge clk);
        checks++; if (OUT_grant !== 2'b01) begin errors++; $display("FAIL wbblock_resume got %b exp 01", OUT_grant); end
        checks++; if (OUT_inflight !== 3'd0) begin errors++; $display("FAIL wbblock_inflight got %0d exp 0", OUT_inflight); end
        flush();
    endtask

    task automatic test_drain();
        logic [1:0] g [3];
        g[0] = 2'b01; g[1] = 2'b10; g[2] = 2'b01;
        for (int c = 1; c <= 3; c++) begin
            clear_inputs();
            IN_reqValid = g[c-1]; IN_reqSqN0 = 7'(39 + c); IN_reqSqN1 = 7'(39 + c);
            @(negedge clk);
            checks++; if (OUT_grant !== g[c-1]) begin errors++; $display("FAIL drain_fill c=%0d got %b exp %b", c, OUT_grant, g[c-1]); end
            next_cycle();
        end
        clear_inputs();
        IN_drain = 1'b1; IN_reqValid = 2'b11; IN_reqSqN0 = 7'd43; IN_reqSqN1 = 7'd44;
        for (int c = 4; c <= 11; c++) begin
            @(negedge clk);
            checks++; if (OUT_grant !== 2'b00) begin errors++; $display("FAIL drain_grant c=%0d got %b exp 00", c, OUT_grant); end
            checks++; if (OUT_wbValid !== (c >= 7 && c <= 9)) begin errors++; $display("FAIL drain_wb c=%0d got %b exp %b", c, OUT_wbValid, (c >= 7 && c <= 9)); end
            checks++; if (OUT_idle !== (c >= 10)) begin errors++; $display("FAIL drain_idle c=%0d got %b exp %b", c, OUT_idle, (c >= 10)); end
            next_cycle();
        end
        IN_drain = 1'b0; IN_reqValid = 2'b01; IN_reqSqN0 = 7'd45;
        @(negedge clk);
        checks++; if (OUT_grant !== 2'b01) begin errors++; $display("FAIL drain_release_grant got %b exp 01", OUT_grant); end
        checks++; if (OUT_idle !== 1'b1) begin errors++; $display("FAIL drain_release_idle got %b exp 1", OUT_idle); end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++; if (OUT_idle !== 1'b0) begin errors++; $display("FAIL drain_run_idle got %b exp 0", OUT_idle); end
        checks++; if (OUT_inflight !== 3'd1) begin errors++; $display("FAIL drain_run_inflight got %0d exp 1", OUT_inflight); end
        next_cycle();
        IN_drain = 1'b1;
        next_cycle();
        // asynchronous reset mid-cycle while sqN 45 is still inside the multiplier
        #2;
        IN_drain = 1'b0; IN_reqValid = 2'b11; IN_reqSqN0 = 7'd46; IN_reqSqN1 = 7'd47;
        rst = 1'b0;
        #1;
        checks++; if (OUT_inflight !== 3'd0) begin errors++; $display("FAIL areset_inflight got %0d exp 0", OUT_inflight); end
        checks++; if (OUT_grant !== 2'b00) begin errors++; $display("FAIL areset_grant got %b exp 00", OUT_grant); end
        checks++; if (OUT_wbValid !== 1'b0) begin errors++; $display("FAIL areset_wb got %b exp 0", OUT_wbValid); end
        checks++; if (OUT_idle !== 1'b0) begin errors++; $display("FAIL areset_idle got %b exp 0", OUT_idle); end
        next_cycle();
        rst = 1'b1;
        clear_inputs();
        IN_drain = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (OUT_wbValid !== 1'b0) begin errors++; $display("FAIL areset_stale_wb k=%0d got %b exp 0", k, OUT_wbValid); end
            checks++; if (OUT_idle !== (k >= 2)) begin errors++; $display("FAIL areset_fsm_idle k=%0d got %b exp %b", k, OUT_idle, (k >= 2)); end
            next_cycle();
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        op_t        q [$];
        op_t        keep [$];
        op_t        op;
        int         mode;
        int         drain_left;
        logic       m_sel;
        logic [6:0] base;
        logic       e0, e1, k0, k1;
        logic [1:0] exp_g;
        logic       exp_sel, exp_wb;
        int         exp_inf;
        rst = 1'b0;
        clear_inputs();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        mode = 0; drain_left = 0; m_sel = 1'b0; base = 7'($urandom_range(0, 127));
        for (int c = 0; c < 600; c++) begin
            base           = base + 7'($urandom_range(0, 2));
            IN_reqValid    = 2'($urandom_range(0, 3));
            IN_reqSqN0     = base + 7'($urandom_range(0, 15));
            IN_reqSqN1     = base + 7'($urandom_range(0, 15));
            IN_branchValid = ($urandom_range(0, 9) == 0);
            IN_branchSqN   = base + 7'($urandom_range(0, 15)) - 7'd8;
            IN_wbBlock     = ($urandom_range(0, 6) == 0);
            if (drain_left > 0) begin
                IN_drain = 1'b1; drain_left--;
            end else if ($urandom_range(0, 40) == 0) begin
                IN_drain = 1'b1; drain_left = $urandom_range(3, 14);
            end else begin
                IN_drain = 1'b0;
            end
            k0 = IN_branchValid && younger(IN_reqSqN0, IN_branchSqN);
            k1 = IN_branchValid && younger(IN_reqSqN1, IN_branchSqN);
            e0 = IN_reqValid[0] && !k0 && !IN_wbBlock && !IN_drain;
            e1 = IN_reqValid[1] && !k1 && !IN_wbBlock && !IN_drain;
            if (e0 && e1) exp_g = younger(IN_reqSqN0, IN_reqSqN1) ? 2'b10 : 2'b01;
            else          exp_g = {e1, e0};
            exp_sel = (exp_g != 2'b00) ? exp_g[1] : m_sel;
            exp_wb  = 1'b0;
            foreach (q[i]) begin
                if (q[i].due == c && !(IN_branchValid && younger(q[i].sqn, IN_branchSqN))) exp_wb = 1'b1;
            end
            exp_inf = q.size();
            @(negedge clk);
            checks++; if (OUT_grant !== exp_g) begin errors++; $display("FAIL rand_grant c=%0d got %b exp %b", c, OUT_grant, exp_g); end
            checks++; if (OUT_en !== (exp_g != 2'b00)) begin errors++; $display("FAIL rand_en c=%0d got %b exp %b", c, OUT_en, (exp_g != 2'b00)); end
            checks++; if (OUT_sel !== exp_sel) begin errors++; $display("FAIL rand_sel c=%0d got %b exp %b", c, OUT_sel, exp_sel); end
            checks++; if (OUT_wbValid !== exp_wb) begin errors++; $display("FAIL rand_wb c=%0d got %b exp %b", c, OUT_wbValid, exp_wb); end
            checks++; if (int'(OUT_inflight) !== exp_inf) begin errors++; $display("FAIL rand_inflight c=%0d got %0d exp %0d", c, OUT_inflight, exp_inf); end
            checks++; if (OUT_idle !== (mode == 2)) begin errors++; $display("FAIL rand_idle c=%0d got %b exp %b", c, OUT_idle, (mode == 2)); end
            keep.delete();
            foreach (q[i]) begin
                if (q[i].due != c && !(IN_branchValid && younger(q[i].sqn, IN_branchSqN))) keep.push_back(q[i]);
            end
            q = keep;
            if (exp_g != 2'b00) begin
                op.sqn = exp_g[1] ? IN_reqSqN1 : IN_reqSqN0;
                op.due = c + LAT;
                q.push_back(op);
            end
            m_sel = exp_sel;
            case (mode)
                0: if (IN_drain) mode = 1;
                1: if (!IN_drain) mode = 0; else if (q.size() == 0) mode = 2;
                default: if (!IN_drain) mode = 0;
            endcase
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_flush();
        test_branch_same_cycle();
        test_wbblock();
        test_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
